// File: rtl/vx_opc_dispatch.sv
// ---------------------------------------------------------------------------
// vx_opc_dispatch
//
// Allocation and dispatch controller for the operand-collector (OPC) slots of
// one issue slice.
//
// Upstream side: each instruction offered by the issue buffer goes to the
// lowest-index FREE slot. The enqueue handshake and slot index feed the OPC
// scheduler.
// Downstream side: every slot is tracked until its register-file reads are
// done. Dependency-free slots are then dispatched round-robin to execute.
//
// Per-slot life cycle:  FREE -> COLLECT -> RDY -> FREE
//
// Optional build macro:
//   VX_OPC_DISPATCH_PERF_EN  adds the perf_alloc_stalls and
//                            perf_dispatch_stalls counter outputs.
//
// Parameters:
//   NUM_OPCS    number of operand-collector slots (>= 1)
//   OPC_WIDTH   slot index width, derived from NUM_OPCS (do not override)
//   PERF_CTR_W  performance counter width (perf build only)
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   in_valid       issue buffer has an instruction
//   in_ready       at least one slot is FREE (independent of in_valid)
//   enqueue_opc    slot allocated to the current enqueue (0 when full)
//   opc_busy       scheduler busy flags; only cross-checked in simulation
//   opc_wait_mask  row i (bits i*NUM_OPCS +: NUM_OPCS) = slots slot i waits on
//   opc_done       one-cycle pulse: slot i finished its register-file reads
//   out_valid      a slot is offered to execute
//   out_ready      execute accepts the offered slot
//   out_opc        offered slot
//   dequeue        out_valid && out_ready
//   dequeue_opc    equal to out_opc
//   perf_alloc_stalls     (perf build) cycles with in_valid && !in_ready
//   perf_dispatch_stalls  (perf build) cycles with a RDY slot but no offer
// ---------------------------------------------------------------------------
module vx_opc_dispatch #(
  parameter int NUM_OPCS  = 4,
  parameter int OPC_WIDTH = (NUM_OPCS > 1) ? $clog2(NUM_OPCS) : 1
`ifdef VX_OPC_DISPATCH_PERF_EN
  ,
  parameter int PERF_CTR_W = 32
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [OPC_WIDTH-1:0]           enqueue_opc,
  input  logic [NUM_OPCS-1:0]            opc_busy,
  input  logic [NUM_OPCS*NUM_OPCS-1:0]   opc_wait_mask,
  input  logic [NUM_OPCS-1:0]            opc_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPC_WIDTH-1:0]           out_opc,
  output logic                           dequeue,
  output logic [OPC_WIDTH-1:0]           dequeue_opc
`ifdef VX_OPC_DISPATCH_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]          perf_alloc_stalls,
  output logic [PERF_CTR_W-1:0]          perf_dispatch_stalls
`endif
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_COLLECT = 2'd1,
    SLOT_RDY     = 2'd2
  } slot_state_e;

  slot_state_e state      [NUM_OPCS];
  slot_state_e state_next [NUM_OPCS];

  logic [NUM_OPCS-1:0]  slot_free;
  logic [NUM_OPCS-1:0]  slot_rdy;
  logic [NUM_OPCS-1:0]  eligible;
  logic [NUM_OPCS-1:0]  elig_upper;
  logic [OPC_WIDTH-1:0] rr_ptr;
  logic [OPC_WIDTH-1:0] rr_pick;
  logic [OPC_WIDTH-1:0] rr_next;
  logic [OPC_WIDTH-1:0] lock_opc;
  logic                 lock_valid;
  logic                 enq_fire;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [OPC_WIDTH-1:0] lowest_set(input logic [NUM_OPCS-1:0] vec);
    logic [OPC_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_OPCS - 1; i >= 0; i--) begin
      idx = vec[i] ? OPC_WIDTH'(i) : idx;
    end
    return idx;
  endfunction

  // Per-slot status vectors derived from the registered slot states.
  always_comb begin
    slot_free  = '0;
    slot_rdy   = '0;
    eligible   = '0;
    elig_upper = '0;
    for (int i = 0; i < NUM_OPCS; i++) begin
      slot_free[i]  = (state[i] == SLOT_FREE);
      slot_rdy[i]   = (state[i] == SLOT_RDY);
      eligible[i]   = slot_rdy[i] &&
                      (opc_wait_mask[i*NUM_OPCS +: NUM_OPCS] == {NUM_OPCS{1'b0}});
      // Eligible slots at or above the round-robin pointer win first; when
      // none exist the search wraps to the lowest eligible slot overall.
      elig_upper[i] = eligible[i] && (OPC_WIDTH'(i) >= rr_ptr);
    end
  end

  // Allocation side: lowest FREE slot, offered regardless of in_valid.
  assign in_ready    = |slot_free;
  assign enqueue_opc = lowest_set(slot_free);
  assign enq_fire    = in_valid && in_ready;

  // Dispatch side. A locked offer holds out_opc steady while execute stalls,
  // so a slot that becomes eligible later can never preempt it.
  assign rr_pick     = (|elig_upper) ? lowest_set(elig_upper) : lowest_set(eligible);
  assign out_valid   = lock_valid || (|eligible);
  assign out_opc     = lock_valid ? lock_opc : rr_pick;
  assign dequeue     = out_valid && out_ready;
  assign dequeue_opc = out_opc;

  // Pointer moves to the slot after the one just dispatched, wrapping at NUM_OPCS.
  assign rr_next = (dequeue_opc == OPC_WIDTH'(NUM_OPCS - 1)) ?
                   {OPC_WIDTH{1'b0}} : (dequeue_opc + OPC_WIDTH'(1));

  // Per-slot next-state logic. A slot can only be allocated while FREE and
  // only be dequeued while RDY, so both can never hit one slot in one cycle.
  always_comb begin
    for (int i = 0; i < NUM_OPCS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        SLOT_FREE: begin
          if (enq_fire && (enqueue_opc == OPC_WIDTH'(i))) begin
            state_next[i] = SLOT_COLLECT;
          end else begin
            state_next[i] = SLOT_FREE;
          end
        end
        SLOT_COLLECT: begin
          if (opc_done[i]) begin
            state_next[i] = SLOT_RDY;
          end else begin
            state_next[i] = SLOT_COLLECT;
          end
        end
        SLOT_RDY: begin
          if (dequeue && (dequeue_opc == OPC_WIDTH'(i))) begin
            state_next[i] = SLOT_FREE;
          end else begin
            state_next[i] = SLOT_RDY;
          end
        end
        default: begin
          state_next[i] = SLOT_FREE;
        end
      endcase
    end
  end

  // Slot state registers; reset drops every in-flight slot at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OPCS; i++) begin
        state[i] <= SLOT_FREE;
      end
    end else begin
      for (int i = 0; i < NUM_OPCS; i++) begin
        state[i] <= state_next[i];
      end
    end
  end

  // Round-robin pointer and offer lock. The lock is taken on the first cycle
  // an offer is stalled and released when that offer is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_opc   <= '0;
    end else if (dequeue) begin
      rr_ptr     <= rr_next;
      lock_valid <= 1'b0;
    end else if (out_valid && !lock_valid) begin
      lock_valid <= 1'b1;
      lock_opc   <= rr_pick;
    end
  end

`ifdef VX_OPC_DISPATCH_PERF_EN
  // Stall counters; both wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_alloc_stalls    <= '0;
      perf_dispatch_stalls <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        perf_alloc_stalls <= perf_alloc_stalls + PERF_CTR_W'(1);
      end
      // A RDY slot with nothing offered means every RDY slot is blocked by a dependency.
      if ((|slot_rdy) && !out_valid) begin
        perf_dispatch_stalls <= perf_dispatch_stalls + PERF_CTR_W'(1);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // The scheduler's busy flags must mirror the slot occupancy.
  a_busy_tracks_state: assert property (
    @(posedge clk) disable iff (!reset) (opc_busy == ~slot_free));

  // A register-file completion can only belong to an occupied slot.
  a_done_not_free: assert property (
    @(posedge clk) disable iff (!reset) ((opc_done & slot_free) == {NUM_OPCS{1'b0}}));
`endif

endmodule

// File: tb/tb_vx_opc_dispatch.sv
// ---------------------------------------------------------------------------
// tb_vx_opc_dispatch
//
// Self-checking bench for vx_opc_dispatch with four slots. A behavioural
// model of the slot occupancy, round-robin pointer and offer lock predicts
// the outputs each cycle. Every predicted dispatch is queued and popped
// when the DUT dequeues, and each scenario also checks its dispatch order
// against a hand-written sequence. The bench plays the OPC scheduler: it
// drives opc_busy from the model and maintains opc_wait_mask.
// ---------------------------------------------------------------------------
module tb_vx_opc_dispatch;

  localparam int N = 4;
  localparam int W = 2;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       enqueue_opc;
  logic [N-1:0]       opc_busy;
  logic [N*N-1:0]     opc_wait_mask;
  logic [N-1:0]       opc_done;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_opc;
  logic               dequeue;
  logic [W-1:0]       dequeue_opc;
`ifdef VX_OPC_DISPATCH_PERF_EN
  logic [31:0]        perf_alloc_stalls;
  logic [31:0]        perf_dispatch_stalls;
  int                 m_perf_alloc;
  int                 m_perf_disp;
`endif

  int          vectors;
  int          miscompares;
  int          m_state [N];   // 0 FREE, 1 COLLECT, 2 RDY
  int          m_rr;
  bit          m_lock;
  int          m_lock_opc;
  bit          m_in_ready;
  int          m_enq;
  bit          m_ov;
  int          m_oo;
  int          exp_deq_q [$];
  logic [31:0] deq_log;       // one nibble per observed dispatch: slot+1
  logic [N-1:0] pend_row;     // wait-mask row given to the next enqueued slot

  vx_opc_dispatch dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .enqueue_opc          (enqueue_opc),
    .opc_busy             (opc_busy),
    .opc_wait_mask        (opc_wait_mask),
    .opc_done             (opc_done),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_opc              (out_opc),
    .dequeue              (dequeue),
    .dequeue_opc          (dequeue_opc)
`ifdef VX_OPC_DISPATCH_PERF_EN
    ,
    .perf_alloc_stalls    (perf_alloc_stalls),
    .perf_dispatch_stalls (perf_dispatch_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_state[i] = 0;
    m_rr       = 0;
    m_lock     = 1'b0;
    m_lock_opc = 0;
`ifdef VX_OPC_DISPATCH_PERF_EN
    m_perf_alloc = 0;
    m_perf_disp  = 0;
`endif
  endtask

  // Predicted combinational outputs for the current model state and inputs.
  task automatic model_eval();
    m_in_ready = 1'b0;
    m_enq      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_state[i] == 0) begin
        m_in_ready = 1'b1;
        m_enq      = i;
      end
    end
    m_ov = 1'b0;
    m_oo = 0;
    if (m_lock) begin
      m_ov = 1'b1;
      m_oo = m_lock_opc;
    end else begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (!m_ov && m_state[s] == 2 && opc_wait_mask[s*N +: N] == '0) begin
          m_ov = 1'b1;
          m_oo = s;
        end
      end
    end
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next.
  task automatic step(input logic iv, input logic [N-1:0] done, input logic ordy, input string tag);
    logic [N-1:0] done_eff;
    bit deq;
    bit enq;
    bit any_rdy;
    for (int i = 0; i < N; i++) opc_busy[i] = (m_state[i] != 0);
    done_eff  = done & opc_busy;
    in_valid  = iv;
    opc_done  = done_eff;
    out_ready = ordy;
    model_eval();
    deq     = m_ov && ordy;
    enq     = iv && m_in_ready;
    any_rdy = 1'b0;
    for (int i = 0; i < N; i++) any_rdy = any_rdy || (m_state[i] == 2);

    @(negedge clk);
    check_eq({tag, ".in_ready"},    32'(in_ready),    32'(m_in_ready));
    check_eq({tag, ".enqueue_opc"}, 32'(enqueue_opc), 32'(m_enq));
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'(m_ov));
    if (m_ov) check_eq({tag, ".out_opc"}, 32'(out_opc), 32'(m_oo));
    check_eq({tag, ".dequeue"},     32'(dequeue),     32'(deq));
    if (deq) exp_deq_q.push_back(m_oo);
    if (dequeue) begin
      deq_log = (deq_log << 4) | (32'(dequeue_opc) + 32'd1);
      if (exp_deq_q.size() == 0) begin
        check_eq({tag, ".unexpected_dequeue"}, 32'(dequeue_opc), 32'hFFFF_FFFF);
      end else begin
        check_eq({tag, ".dequeue_opc"}, 32'(dequeue_opc), 32'(exp_deq_q.pop_front()));
      end
    end

    @(posedge clk);
    #1;
`ifdef VX_OPC_DISPATCH_PERF_EN
    if (iv && !m_in_ready) m_perf_alloc++;
    if (any_rdy && !m_ov) m_perf_disp++;
`endif
    for (int i = 0; i < N; i++) begin
      if (m_state[i] == 1 && done_eff[i]) m_state[i] = 2;
      else if (m_state[i] == 2 && deq && m_oo == i) m_state[i] = 0;
    end
    if (enq) begin
      m_state[m_enq] = 1;
      opc_wait_mask[m_enq*N +: N] = pend_row;
    end
    if (deq) begin
      for (int r = 0; r < N; r++) opc_wait_mask[r*N + m_oo] = 1'b0;
      m_rr   = (m_oo + 1) % N;
      m_lock = 1'b0;
    end else if (m_ov && !m_lock) begin
      m_lock     = 1'b1;
      m_lock_opc = m_oo;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".in_ready"},    32'(in_ready),    32'd1);
    check_eq({tag, ".enqueue_opc"}, 32'(enqueue_opc), 32'd0);
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'd0);
    check_eq({tag, ".dequeue"},     32'(dequeue),     32'd0);
    check_eq({tag, ".out_opc"},     32'(out_opc),     32'd0);
    check_eq({tag, ".dequeue_opc"}, 32'(dequeue_opc), 32'd0);
`ifdef VX_OPC_DISPATCH_PERF_EN
    check_eq({tag, ".perf_alloc"},  perf_alloc_stalls,    32'd0);
    check_eq({tag, ".perf_disp"},   perf_dispatch_stalls, 32'd0);
`endif
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    in_valid      = 1'b0;
    opc_done      = '0;
    opc_busy      = '0;
    opc_wait_mask = '0;
    out_ready     = 1'b0;
    pend_row      = '0;
    deq_log       = '0;
    model_reset();

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill: slots allocated 0,1,2,3; fifth cycle sees a full controller.
    for (int c = 0; c < 5; c++) step(1'b1, 4'b0000, 1'b0, "fill");
    step(1'b0, 4'b1111, 1'b0, "fill.done");
    deq_log = '0;
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0000, 1'b1, "fill.drain");
    check_eq("fill.order", deq_log, 32'h0000_1234);
    check_eq("fill.count", 32'(exp_deq_q.size()), 32'd0);

    // Stability: slot 0 locked while execute stalls; slot 1 joins late.
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0000, 1'b0, "stab.enq");
    step(1'b0, 4'b0101, 1'b0, "stab.done02");
    step(1'b0, 4'b0000, 1'b0, "stab.hold0");
    step(1'b0, 4'b0000, 1'b0, "stab.hold1");
    step(1'b0, 4'b0010, 1'b0, "stab.hold2");
    step(1'b0, 4'b0000, 1'b0, "stab.hold3");
    deq_log = '0;
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, 1'b1, "stab.grant");
    check_eq("stab.order", deq_log, 32'h0000_0123);

    // Minimum latency: enqueue t, done t+1, dispatch t+2, FREE again at t+3.
    deq_log = '0;
    step(1'b1, 4'b0000, 1'b1, "lat.enq");
    step(1'b0, 4'b0001, 1'b1, "lat.done");
    check_eq("lat.no_early", deq_log, 32'd0);
    step(1'b0, 4'b0000, 1'b1, "lat.disp");
    check_eq("lat.order", deq_log, 32'h0000_0001);
    step(1'b0, 4'b0000, 1'b0, "lat.free");

    // Dependency: slot 1 waits on slot 0 and dispatches only after it.
    deq_log  = '0;
    pend_row = 4'b0000;
    step(1'b1, 4'b0000, 1'b0, "dep.enq0");
    pend_row = 4'b0001;
    step(1'b1, 4'b0000, 1'b0, "dep.enq1");
    pend_row = 4'b0000;
    step(1'b0, 4'b0011, 1'b0, "dep.done");
    step(1'b0, 4'b0000, 1'b0, "dep.offer");
    step(1'b0, 4'b0000, 1'b1, "dep.t");
    check_eq("dep.after_t", deq_log, 32'h0000_0001);
    step(1'b0, 4'b0000, 1'b1, "dep.t1");
    check_eq("dep.order", deq_log, 32'h0000_0012);

    // Full: dequeue slot 2 while in_valid waits; slot 2 reallocated next cycle.
    for (int c = 0; c < 4; c++) step(1'b1, 4'b0000, 1'b0, "full.enq");
    step(1'b0, 4'b0100, 1'b0, "full.done2");
    deq_log = '0;
    step(1'b1, 4'b0000, 1'b1, "full.t");
    step(1'b1, 4'b0000, 1'b0, "full.t1");
    check_eq("full.order", deq_log, 32'h0000_0003);

    // Three slots RDY with an offer pending, then reset mid-operation.
    step(1'b0, 4'b1011, 1'b0, "rst.done");
    step(1'b0, 4'b0000, 1'b0, "rst.offer");
`ifdef VX_OPC_DISPATCH_PERF_EN
    check_eq("perf.alloc", perf_alloc_stalls,    32'(m_perf_alloc));
    check_eq("perf.disp",  perf_dispatch_stalls, 32'(m_perf_disp));
`endif
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    in_valid      = 1'b0;
    opc_done      = '0;
    out_ready     = 1'b0;
    opc_busy      = '0;
    opc_wait_mask = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Normal operation resumes from slot 0.
    step(1'b1, 4'b0000, 1'b0, "post.enq");

    check_eq("sb.drained", 32'(exp_deq_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
